// File: rtl/spi_top.sv
// Loop-back SPI link (mode 0): master and slave cores in one clock domain, wired back-to-back.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting at both ends; default is MSB first.
module spi_top #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] master_din,
  input  logic [WIDTH-1:0] slave_din,
  output logic [WIDTH-1:0] master_dout,
  output logic [WIDTH-1:0] slave_dout,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  output logic             miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

  // Bit-order helpers shared by both ends so the two cores can never disagree.
`ifdef SPI_LSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return v[0];
  endfunction
  function automatic logic next_bit(input logic [WIDTH-1:0] v);
    return v[1];
  endfunction
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return v >> 1;
  endfunction
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    return {b, v[WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction
  function automatic logic next_bit(input logic [WIDTH-1:0] v);
    return v[WIDTH-2];
  endfunction
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return v << 1;
  endfunction
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    return {v[WIDTH-2:0], b};
  endfunction
`endif

  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_XFER, M_HOLD} m_state_t;
  typedef enum logic       {S_IDLE, S_ACTIVE}               s_state_t;

  m_state_t          m_state;
  logic [WIDTH-1:0]  m_tx;
  logic [WIDTH-1:0]  m_rx;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;

  s_state_t          s_state;
  logic [WIDTH-1:0]  s_tx;
  logic [WIDTH-1:0]  s_rx;
  logic              sclk_q;
  logic              cs_q;

  // Master: owns SCLK/CS_N/MOSI and publishes both results at the end of HOLD.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_state     <= M_IDLE;
      m_tx        <= '0;
      m_rx        <= '0;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      sclk        <= 1'b0;
      cs_n        <= 1'b1;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      master_dout <= '0;
      slave_dout  <= '0;
    end else begin
      done <= 1'b0;
      case (m_state)
        M_IDLE: begin
          if (start) begin
            m_tx    <= master_din;
            busy    <= 1'b1;
            m_state <= M_LOAD;
          end
        end
        M_LOAD: begin
          cs_n     <= 1'b0;
          mosi     <= first_bit(m_tx);
          m_rx     <= '0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          m_state  <= M_XFER;
        end
        M_XFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (!sclk) begin
              m_rx <= shift_in(m_rx, miso);
            end else begin
              m_tx <= shift_out(m_tx);
              mosi <= next_bit(m_tx);
            end
            if (edge_cnt == EDGE_LAST) m_state <= M_HOLD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        M_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            cs_n        <= 1'b1;
            busy        <= 1'b0;
            mosi        <= 1'b0;
            master_dout <= m_rx;
            slave_dout  <= s_rx;
            done        <= 1'b1;
            m_state     <= M_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  // Slave: oversamples SCLK and CS_N on clk; edges are seen one cycle late,
  // which fits inside the CLK_DIV >= 2 half-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_state <= S_IDLE;
      s_tx    <= '0;
      s_rx    <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      miso    <= 1'b0;
    end else begin
      sclk_q <= sclk;
      cs_q   <= cs_n;
      case (s_state)
        S_IDLE: begin
          miso <= 1'b0;
          if (!cs_n && cs_q) begin
            s_tx    <= slave_din;
            s_rx    <= '0;
            miso    <= first_bit(slave_din);
            s_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (cs_n) begin
            miso    <= 1'b0;
            s_state <= S_IDLE;
          end else if (sclk && !sclk_q) begin
            s_rx <= shift_in(s_rx, mosi);
          end else if (!sclk && sclk_q) begin
            s_tx <= shift_out(s_tx);
            miso <= next_bit(s_tx);
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_top.sv
// Scoreboard bench for spi_top: expected words are queued at start and checked at done.
module tb_spi_top;

`ifdef SPI_LSB_FIRST_EN
  localparam int CLK_DIV = 2;
`else
  localparam int CLK_DIV = 4;
`endif
  localparam int XFER_LAT = 1 + 17 * CLK_DIV;
  localparam int CS_LOW   = 17 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] master_din;
  logic [7:0] slave_din;
  logic [7:0] master_dout;
  logic [7:0] slave_dout;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  spi_top #(.CLK_DIV(CLK_DIV), .WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .master_din  (master_din),
    .slave_din   (slave_din),
    .master_dout (master_dout),
    .slave_dout  (slave_dout),
    .busy        (busy),
    .done        (done),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m_exp;
    logic [7:0] s_exp;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   low_run  = 0;
  int   last_low = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: measures the CS_N low window and scores each done pulse.
  always @(negedge clk) begin
    if (!cs_n) begin
      low_run++;
    end else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
    if (done) begin
      done_cnt++;
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("master_dout", master_dout, e.m_exp);
        check("slave_dout",  slave_dout,  e.s_exp);
        check("done_latency", cyc - e.t0, XFER_LAT);
        check("cs_low_len",  last_low,    CS_LOW);
      end
    end
  end

  // Drives a one-cycle start; with no_wait the pulse begins at the current negedge.
  task automatic start_xfer(input logic [7:0] m, input logic [7:0] s, input bit no_wait);
    exp_t e;
    if (!no_wait) @(negedge clk);
    master_din = m;
    slave_din  = s;
    start      = 1'b1;
    e.m_exp = s;
    e.s_exp = m;
    e.t0    = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_no_timeout"}, n < 400, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1;
    start = 1'b0;
    master_din = 8'h00;
    slave_din  = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_master_dout", master_dout, 0);
    check("rst_slave_dout",  slave_dout,  0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_miso", miso, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic exchange.
    d0 = done_cnt;
    start_xfer(8'hAA, 8'hCC, 1'b0);
    wait_done("basic");
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_cs_n", cs_n, 1);
    check("idle_busy", busy, 0);
    check("dout_hold_m", master_dout, 8'hCC);

    // Second start while busy must be ignored.
    d0 = done_cnt;
    start_xfer(8'h3C, 8'h96, 1'b0);
    repeat (20) @(negedge clk);
    master_din = 8'h11;
    slave_din  = 8'h22;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ign");
    repeat (80) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    // Back-to-back: second start in the cycle right after done.
    d0 = done_cnt;
    start_xfer(8'h00, 8'hFF, 1'b0);
    wait_done("b2b_first");
    start_xfer(8'hFF, 8'h00, 1'b1);
    wait_done("b2b_second");
    @(negedge clk);
    check("b2b_two_dones", done_cnt - d0, 2);

    // Reset mid-transfer aborts and clears the results.
    start_xfer(8'h12, 8'h34, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    d0 = done_cnt;
    check("abort_master_dout", master_dout, 0);
    check("abort_slave_dout",  slave_dout,  0);
    check("abort_cs_n", cs_n, 1);
    check("abort_busy", busy, 0);
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    start_xfer(8'h5A, 8'hA5, 1'b0);
    wait_done("after_abort");

    // Reset and start together: reset wins.
    @(negedge clk);
    reset      = 1'b1;
    start      = 1'b1;
    master_din = 8'h77;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", busy, 0);
    check("rst_wins_cs_n", cs_n, 1);

    // Asymmetric bit pattern exposes any bit-order error.
    start_xfer(8'h81, 8'h3C, 1'b0);
    wait_done("pattern_81");
    start_xfer(8'h01, 8'h80, 1'b0);
    wait_done("pattern_01");

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
